// File: rtl/smoldvi_timing_pkg.sv
// Shared definitions for the smoldvi video timing generator: axis state
// encoding, the default 640x480@60 timing set and counter sizing.
package smoldvi_timing_pkg;

    typedef enum logic [1:0] {
        ST_FRONT  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_BACK   = 2'd2,
        ST_ACTIVE = 2'd3
    } axis_state_e;

    // Default 640x480@60 timing
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_SYNC_WIDTH  = 96;
    localparam int DEF_H_BACK_PORCH  = 48;
    localparam int DEF_H_ACTIVE      = 640;
    localparam int DEF_V_FRONT_PORCH = 10;
    localparam int DEF_V_SYNC_WIDTH  = 2;
    localparam int DEF_V_BACK_PORCH  = 33;
    localparam int DEF_V_ACTIVE      = 480;

    // Counter width for an axis: enough bits for the longest state, plus one
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/smoldvi_timing_axis.sv
// One timing axis: a FRONT->SYNC->BACK->ACTIVE sequencer with a per-state
// counter. The next-state values are exported so the parent can register
// its output decode without adding latency relative to the axis state.
module smoldvi_timing_axis
    import smoldvi_timing_pkg::*;
#(
    parameter int FRONT  = 1,
    parameter int SYNC   = 1,
    parameter int BACK   = 1,
    parameter int ACTIVE = 1,
    parameter int CW     = cnt_width(FRONT, SYNC, BACK, ACTIVE)
) (
    input  logic          clk_pix,
    input  logic          rst_n_pix,
    input  logic          clr,
    input  logic          step,
    output logic          last_of_active,
    output axis_state_e   next_state,
    output logic [CW-1:0] next_cnt
);

    localparam logic [CW-1:0] LAST_FRONT  = CW'(FRONT - 1);
    localparam logic [CW-1:0] LAST_SYNC   = CW'(SYNC - 1);
    localparam logic [CW-1:0] LAST_BACK   = CW'(BACK - 1);
    localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);

    axis_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last_cnt_s;
    logic          state_end_s;

    // Terminal count of the current state and the end-of-active flag
    always_comb begin
        last_cnt_s = LAST_ACTIVE;
        case (state_q)
            ST_FRONT:  last_cnt_s = LAST_FRONT;
            ST_SYNC:   last_cnt_s = LAST_SYNC;
            ST_BACK:   last_cnt_s = LAST_BACK;
            ST_ACTIVE: last_cnt_s = LAST_ACTIVE;
            default:   last_cnt_s = LAST_ACTIVE;
        endcase
        state_end_s    = (cnt_q == last_cnt_s);
        last_of_active = (state_q == ST_ACTIVE) && state_end_s;
    end

    // Next state: clear to origin, otherwise count and advance on terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_FRONT;
            cnt_d   = {CW{1'b0}};
        end else if (step) begin
            if (state_end_s) begin
                cnt_d = {CW{1'b0}};
                case (state_q)
                    ST_FRONT:  state_d = ST_SYNC;
                    ST_SYNC:   state_d = ST_BACK;
                    ST_BACK:   state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_FRONT;
                    default:   state_d = ST_FRONT;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            state_q <= ST_FRONT;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign next_state = state_d;
    assign next_cnt   = cnt_d;

endmodule

// File: rtl/smoldvi_timing.sv
// DVI video timing generator. Two axis sequencers (horizontal in pixels,
// vertical in lines) drive flop-based hsync/vsync/den/rgb_rdy/sof/eol.
// Outputs are registered from the axes' next state, so in every cycle they
// decode exactly the current axis state.
module smoldvi_timing
    import smoldvi_timing_pkg::*;
#(
    parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int   H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int   V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
    parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter logic H_SYNC_POL    = 1'b0,
    parameter logic V_SYNC_POL    = 1'b0
) (
    input  logic clk_pix,
    input  logic rst_n_pix,
    input  logic en,
    output logic hsync,
    output logic vsync,
    output logic den,
    output logic rgb_rdy,
    output logic sof,
    output logic eol
);

    localparam int HW = cnt_width(H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH, H_ACTIVE);
    localparam int VW = cnt_width(V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH, V_ACTIVE);
    localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);

    axis_state_e h_next_state_s, v_next_state_s;
    logic [HW-1:0] h_next_cnt_s;
    logic [VW-1:0] v_next_cnt_s;
    logic h_eol_s;
    logic v_frame_end_unused_s;
    logic hsync_d, vsync_d, den_d, sof_d, eol_d;
    logic hsync_q, vsync_q, den_q, sof_q, eol_q;

    smoldvi_timing_axis #(
        .FRONT (H_FRONT_PORCH),
        .SYNC  (H_SYNC_WIDTH),
        .BACK  (H_BACK_PORCH),
        .ACTIVE(H_ACTIVE),
        .CW    (HW)
    ) u_h_axis (
        .clk_pix       (clk_pix),
        .rst_n_pix     (rst_n_pix),
        .clr           (~en),
        .step          (en),
        .last_of_active(h_eol_s),
        .next_state    (h_next_state_s),
        .next_cnt      (h_next_cnt_s)
    );

    // Vertical axis advances one line on each horizontal end-of-line
    smoldvi_timing_axis #(
        .FRONT (V_FRONT_PORCH),
        .SYNC  (V_SYNC_WIDTH),
        .BACK  (V_BACK_PORCH),
        .ACTIVE(V_ACTIVE),
        .CW    (VW)
    ) u_v_axis (
        .clk_pix       (clk_pix),
        .rst_n_pix     (rst_n_pix),
        .clr           (~en),
        .step          (h_eol_s & en),
        .last_of_active(v_frame_end_unused_s),
        .next_state    (v_next_state_s),
        .next_cnt      (v_next_cnt_s)
    );

    // Output decode of the state the axes enter at the coming edge
    always_comb begin
        hsync_d = (h_next_state_s == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = (v_next_state_s == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        den_d   = (h_next_state_s == ST_ACTIVE) && (v_next_state_s == ST_ACTIVE);
        sof_d   = den_d && (h_next_cnt_s == {HW{1'b0}}) && (v_next_cnt_s == {VW{1'b0}});
        eol_d   = den_d && (h_next_cnt_s == H_LAST_ACT);
    end

    // Output registers; reset values match the frame-origin decode
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            den_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            den_q   <= den_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign den     = den_q;
    assign rgb_rdy = den_q;
    assign sof     = sof_q;
    assign eol     = eol_q;

endmodule

// File: tb/tb_smoldvi_timing.sv
// Bench for smoldvi_timing: three instances (default 640x480, a small odd
// timing with positive hsync, and all-ones timing) checked every cycle
// against an arithmetic model of position P within the frame.
module tb_smoldvi_timing;
    import smoldvi_timing_pkg::*;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic rst_n_pix = 1'b0;
    logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
    logic hs_a, vs_a, den_a, rdy_a, sof_a, eol_a;
    logic hs_b, vs_b, den_b, rdy_b, sof_b, eol_b;
    logic hs_c, vs_c, den_c, rdy_c, sof_c, eol_c;

    int p_a = 0, p_b = 0, p_c = 0;
    int n_pass = 0, n_total = 0;
    int first_den_p = -1;
    bit seen_den = 1'b0;

    smoldvi_timing u_dut_a (
        .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .en(en_a),
        .hsync(hs_a), .vsync(vs_a), .den(den_a), .rgb_rdy(rdy_a), .sof(sof_a), .eol(eol_a)
    );

    smoldvi_timing #(
        .H_FRONT_PORCH(3), .H_SYNC_WIDTH(2), .H_BACK_PORCH(4), .H_ACTIVE(5),
        .V_FRONT_PORCH(2), .V_SYNC_WIDTH(1), .V_BACK_PORCH(3), .V_ACTIVE(4),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) u_dut_b (
        .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .en(en_b),
        .hsync(hs_b), .vsync(vs_b), .den(den_b), .rgb_rdy(rdy_b), .sof(sof_b), .eol(eol_b)
    );

    smoldvi_timing #(
        .H_FRONT_PORCH(1), .H_SYNC_WIDTH(1), .H_BACK_PORCH(1), .H_ACTIVE(1),
        .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1), .V_ACTIVE(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) u_dut_c (
        .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .en(en_c),
        .hsync(hs_c), .vsync(vs_c), .den(den_c), .rgb_rdy(rdy_c), .sof(sof_c), .eol(eol_c)
    );

    // Expected {hsync, vsync, den, rgb_rdy, sof, eol} at frame position p
    function automatic logic [5:0] model(input int p, input int hf, input int hs, input int hb,
                                         input int ha, input int vf, input int vs, input int vb,
                                         input int va, input logic hpol, input logic vpol);
        int ht, vt, hp, ln;
        logic hsy, vsy, de;
        ht  = hf + hs + hb + ha;
        vt  = vf + vs + vb + va;
        hp  = p % ht;
        ln  = (p / ht) % vt;
        hsy = (hp >= hf) && (hp < hf + hs);
        vsy = (ln >= vf) && (ln < vf + vs);
        de  = (hp >= hf + hs + hb) && (ln >= vf + vs + vb);
        return {hsy ? hpol : ~hpol, vsy ? vpol : ~vpol, de, de,
                de && (hp == hf + hs + hb) && (ln == vf + vs + vb),
                de && (hp == ht - 1)};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp, input int p);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s p=%0d observed=%b expected=%b", tag, p, obs, exp);
    endtask

    task automatic check_all();
        check("dflt", {hs_a, vs_a, den_a, rdy_a, sof_a, eol_a},
              model(p_a, DEF_H_FRONT_PORCH, DEF_H_SYNC_WIDTH, DEF_H_BACK_PORCH, DEF_H_ACTIVE,
                    DEF_V_FRONT_PORCH, DEF_V_SYNC_WIDTH, DEF_V_BACK_PORCH, DEF_V_ACTIVE,
                    1'b0, 1'b0), p_a);
        check("small", {hs_b, vs_b, den_b, rdy_b, sof_b, eol_b},
              model(p_b, 3, 2, 4, 5, 2, 1, 3, 4, 1'b1, 1'b0), p_b);
        check("ones", {hs_c, vs_c, den_c, rdy_c, sof_c, eol_c},
              model(p_c, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b1), p_c);
    endtask

    // One clock: advance model positions, check, then pick new random enables
    task automatic tick();
        @(posedge clk_pix);
        p_a = (rst_n_pix && en_a) ? p_a + 1 : 0;
        p_b = (rst_n_pix && en_b) ? p_b + 1 : 0;
        p_c = (rst_n_pix && en_c) ? p_c + 1 : 0;
        #1;
        check_all();
        if (den_a && !seen_den) begin
            seen_den    = 1'b1;
            first_den_p = p_a;
        end
        en_b = ($urandom_range(0, 399) != 0);
        en_c = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        // Reset values while held in reset
        #8;
        check_all();
        #4;
        rst_n_pix = 1'b1;

        // Free run from reset release to P = 36500
        repeat (36500) tick();
        check("first_den", 6'(first_den_p), 6'(36160 % 64), first_den_p);
        n_total++;
        assert (first_den_p == 36160) n_pass++;
        else $error("FAIL first_den_pos observed=%0d expected=%0d", first_den_p, 36160);

        // Drop en mid-active: origin on the next edge
        en_a = 1'b0;
        tick();
        check("en_drop", {hs_a, vs_a, den_a, rdy_a, sof_a, eol_a}, 6'b110000, p_a);

        // Re-raise: first den after exactly 36160 enabled cycles, first eol follows
        en_a     = 1'b1;
        seen_den = 1'b0;
        repeat (36800) tick();
        n_total++;
        assert (first_den_p == 36160) n_pass++;
        else $error("FAIL restart_den_pos observed=%0d expected=%0d", first_den_p, 36160);

        // Move into hsync, then pulse async reset between clock edges
        repeat (50) tick();
        check("mid_hsync", {5'b00000, hs_a}, 6'b000000, p_a);
        #2;
        rst_n_pix = 1'b0;
        #1;
        p_a = 0;
        p_b = 0;
        p_c = 0;
        check_all();
        repeat (2) tick();
        #2;
        rst_n_pix = 1'b1;

        // Timeline after release matches the fresh-reset timeline
        repeat (1000) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
